// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall bus layout, stall
// encodings and FSM state encoding.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  localparam stall_bus_t STALL_NONE   = 6'b000000;
  localparam stall_bus_t STALL_FROM_IF  = 6'b000011;
  localparam stall_bus_t STALL_FROM_ID  = 6'b000111;
  localparam stall_bus_t STALL_FROM_MEM = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_stall_prio.sv
// Combinational stall priority encoder: mem > id > if.
module stall_prio
  import pipe_ctrl_pkg::*;
(
  input  logic                 i_if_stallreq,
  input  logic                 i_id_stallreq,
  input  logic                 i_mem_stallreq,
  output logic [STALL_W-1:0]   o_stall
);

  always_comb begin
    o_stall = STALL_NONE;
    if (i_mem_stallreq)
      o_stall = STALL_FROM_MEM;
    else if (i_id_stallreq)
      o_stall = STALL_FROM_ID;
    else if (i_if_stallreq)
      o_stall = STALL_FROM_IF;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall bus generation plus branch redirect/flush FSM.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_stallreq,
  input  logic                 id_stallreq,
  input  logic                 mem_stallreq,
  input  logic                 id_b_flag_i,
  input  logic [31:0]          id_b_target_i,
  input  logic                 ex_b_flag_i,
  input  logic [31:0]          ex_b_target_i,
  output logic [STALL_W-1:0]   stall,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush_if_id,
  output logic                 flush_id_ex
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_redirects
`endif
);

  state_t      r_state;
  logic [31:0] r_pend_pc;
  logic        r_pend_ex;

  logic        w_br;
  logic [31:0] w_br_tgt;
  logic [31:0] w_pend_tgt;
  logic        w_pend_ex;

  stall_prio u_stall_prio (
    .i_if_stallreq  (if_stallreq),
    .i_id_stallreq  (id_stallreq),
    .i_mem_stallreq (mem_stallreq),
    .o_stall        (stall)
  );

  // The execute-stage branch is older, so it wins over decode; while
  // pending, a late execute branch replaces the held target.
  always_comb begin
    w_br       = ex_b_flag_i | id_b_flag_i;
    w_br_tgt   = ex_b_flag_i ? ex_b_target_i : id_b_target_i;
    w_pend_tgt = ex_b_flag_i ? ex_b_target_i : r_pend_pc;
    w_pend_ex  = ex_b_flag_i | r_pend_ex;
  end

  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_br && stall[STALL_PC] == NOSTOP) begin
            redirect_valid = 1'b1;
            redirect_pc    = w_br_tgt;
            flush_if_id    = 1'b1;
            flush_id_ex    = ex_b_flag_i;
          end
        end
        ST_PEND: begin
          if (stall[STALL_PC] == NOSTOP) begin
            redirect_valid = 1'b1;
            redirect_pc    = w_pend_tgt;
            flush_if_id    = 1'b1;
            flush_id_ex    = w_pend_ex;
          end else if (stall[STALL_IF] == STOP && stall[STALL_ID] == NOSTOP) begin
            flush_if_id = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (stall[STALL_IF] == NOSTOP)
            flush_if_id = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pend_pc <= '0;
      r_pend_ex <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_br && stall[STALL_PC] == STOP) begin
            r_pend_pc <= w_br_tgt;
            r_pend_ex <= ex_b_flag_i;
            r_state   <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (stall[STALL_PC] == NOSTOP) begin
            r_state <= (stall[STALL_IF] == STOP) ? ST_DRAIN : ST_IDLE;
          end else if (ex_b_flag_i) begin
            r_pend_pc <= ex_b_target_i;
            r_pend_ex <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (stall[STALL_IF] == NOSTOP)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (stall[STALL_PC] == STOP)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirect_valid)
        perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected outputs are queued as each cycle
// is driven and compared when the combinational outputs are sampled.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        if_stallreq;
  logic        id_stallreq;
  logic        mem_stallreq;
  logic        id_b_flag_i;
  logic [31:0] id_b_target_i;
  logic        ex_b_flag_i;
  logic [31:0] ex_b_target_i;
  logic [5:0]  stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_redirects;
  logic [31:0] m_stall_cycles;
  logic [31:0] m_redirects;
`endif

  typedef struct packed {
    logic [5:0]  stall;
    logic        rv;
    logic [31:0] pc;
    logic        fii;
    logic        fie;
  } exp_t;

  exp_t q_exp[$];

  int unsigned n_checks;
  int unsigned n_pass;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .if_stallreq    (if_stallreq),
    .id_stallreq    (id_stallreq),
    .mem_stallreq   (mem_stallreq),
    .id_b_flag_i    (id_b_flag_i),
    .id_b_target_i  (id_b_target_i),
    .ex_b_flag_i    (ex_b_flag_i),
    .ex_b_target_i  (ex_b_target_i),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic step(input string tag,
                      input logic r, input logic ifs, input logic ids, input logic ms,
                      input logic idf, input logic [31:0] idt,
                      input logic exf, input logic [31:0] ext,
                      input logic [5:0] es, input logic erv, input logic [31:0] epc,
                      input logic efii, input logic efie);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    if_stallreq   = ifs;
    id_stallreq   = ids;
    mem_stallreq  = ms;
    id_b_flag_i   = idf;
    id_b_target_i = idt;
    ex_b_flag_i   = exf;
    ex_b_target_i = ext;
    e.stall = es;
    e.rv    = erv;
    e.pc    = epc;
    e.fii   = efii;
    e.fie   = efie;
    q_exp.push_back(e);
    @(negedge clk);
    e = q_exp.pop_front();
    check({tag, ".stall"}, {26'd0, stall}, {26'd0, e.stall});
    check({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, e.rv});
    check({tag, ".redirect_pc"}, redirect_pc, e.pc);
    check({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, e.fii});
    check({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, e.fie});
`ifdef PIPE_CTRL_PERF_EN
    check({tag, ".perf_stall_cycles"}, perf_stall_cycles, m_stall_cycles);
    check({tag, ".perf_redirects"}, perf_redirects, m_redirects);
    if (r) begin
      m_stall_cycles = '0;
      m_redirects    = '0;
    end else begin
      m_stall_cycles = m_stall_cycles + {31'd0, e.stall[0]};
      m_redirects    = m_redirects + {31'd0, e.rv};
    end
`endif
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    if_stallreq   = 1'b0;
    id_stallreq   = 1'b0;
    mem_stallreq  = 1'b0;
    id_b_flag_i   = 1'b0;
    id_b_target_i = '0;
    ex_b_flag_i   = 1'b0;
    ex_b_target_i = '0;
`ifdef PIPE_CTRL_PERF_EN
    m_stall_cycles = '0;
    m_redirects    = '0;
    // Counters are unknown until the first reset edge; prime with reset.
    @(posedge clk);
`endif

    //     tag          rst ifs ids ms idf idt           exf ext           stall      rv pc           fii fie
    step("rst_idle",     1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
    step("rst_stall",    1, 1, 1, 1, 0, 32'h0,        1, 32'h100,      6'b011111, 0, 32'h0,        0, 0);
    step("prio_all",     0, 1, 1, 1, 0, 32'h0,        0, 32'h0,        6'b011111, 0, 32'h0,        0, 0);
    step("prio_no_mem",  0, 1, 1, 0, 0, 32'h0,        0, 32'h0,        6'b000111, 0, 32'h0,        0, 0);
    step("prio_if",      0, 1, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000011, 0, 32'h0,        0, 0);
    step("prio_none",    0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);

    step("ex_br",        0, 0, 0, 0, 0, 32'h0,        1, 32'h100,      6'b000000, 1, 32'h100,      1, 1);
    step("both_br",      0, 0, 0, 0, 1, 32'h200,      1, 32'h300,      6'b000000, 1, 32'h300,      1, 1);
    step("id_br_raw",    0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0,        6'b000000, 1, 32'hDEADBEEF, 1, 0);
    step("quiet0",       0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);

    step("pend_enter",   0, 1, 0, 0, 1, 32'h400,      0, 32'h0,        6'b000011, 0, 32'h0,        0, 0);
    step("pend_idwp",    0, 1, 0, 0, 1, 32'h999,      0, 32'h0,        6'b000011, 0, 32'h0,        1, 0);
    step("pend_hold",    0, 1, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000011, 0, 32'h0,        1, 0);
    step("pend_release", 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000000, 1, 32'h400,      1, 0);
    step("after_rel",    0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);

    step("ovr_enter",    0, 1, 0, 0, 1, 32'h400,      0, 32'h0,        6'b000011, 0, 32'h0,        0, 0);
    step("ovr_ex",       0, 1, 0, 0, 0, 32'h0,        1, 32'h500,      6'b000011, 0, 32'h0,        1, 0);
    step("ovr_idstall",  0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        6'b000111, 0, 32'h0,        0, 0);
    step("ovr_release",  0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000000, 1, 32'h500,      1, 1);
    step("ovr_after",    0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);

    step("mem_br",       0, 0, 0, 1, 0, 32'h0,        1, 32'h600,      6'b011111, 0, 32'h0,        0, 0);
    step("mem_hold",     0, 0, 0, 1, 0, 32'h0,        0, 32'h0,        6'b011111, 0, 32'h0,        0, 0);
    step("mem_release",  0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000000, 1, 32'h600,      1, 1);

    step("rp_enter",     0, 1, 0, 0, 1, 32'h400,      0, 32'h0,        6'b000011, 0, 32'h0,        0, 0);
    step("rp_reset",     1, 1, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000011, 0, 32'h0,        0, 0);
    step("rp_after0",    0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
    step("rp_after1",    0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
